// File: rtl/seq_deadtime_pkg.sv
// Shared state encoding and sizing helper for the seq_deadtime output stage.
package seq_deadtime_pkg;

  typedef enum logic [1:0] {
    SEQDT_OFF  = 2'd0,
    SEQDT_WAIT = 2'd1,
    SEQDT_ON   = 2'd2
  } seqdt_state_e;

  // Counter width clog2(dt+1), kept at least 1 bit so dt=0 still builds.
  function automatic int seqdt_cnt_w(input int dt_v);
    return (dt_v < 1) ? 1 : $clog2(dt_v + 1);
  endfunction

endpackage

// File: rtl/seq_deadtime_chan.sv
// One output channel: OFF/WAIT/ON state machine delaying each rising request by dt clocks.
module seq_deadtime_chan
  import seq_deadtime_pkg::*;
#(
  parameter int dt = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic q_bit,
  output logic waiting
);

  localparam int             CW   = seqdt_cnt_w(dt);
  localparam logic [CW-1:0]  LOAD = (dt > 0) ? CW'(dt - 1) : '0;

  seqdt_state_e  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEQDT_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      SEQDT_OFF: begin
        if (req) begin
          if (dt == 0) begin
            w_state_nxt = SEQDT_ON;
          end else begin
            w_state_nxt = SEQDT_WAIT;
            w_cnt_nxt   = LOAD;
          end
        end
      end
      SEQDT_WAIT: begin
        // A dropped request cancels the pending rise; the counter only moves here.
        if (!req)               w_state_nxt = SEQDT_OFF;
        else if (r_cnt == '0)   w_state_nxt = SEQDT_ON;
        else                    w_cnt_nxt   = r_cnt - 1'b1;
      end
      SEQDT_ON: begin
        if (!req) w_state_nxt = SEQDT_OFF;
      end
      default: w_state_nxt = SEQDT_OFF;
    endcase
  end

  assign q_bit   = (r_state == SEQDT_ON);
  assign waiting = (r_state == SEQDT_WAIT);

endmodule

// File: rtl/seq_deadtime.sv
// Break-before-make output stage for sequencer phase pins.
// Optional complementary-pair interlock with sticky fault: SEQ_DEADTIME_INTERLOCK_EN.
module seq_deadtime
  import seq_deadtime_pkg::*;
#(
  parameter int ddw   = 4,
  parameter int dt    = 3,
  parameter int pairs = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ddw-1:0] d,
  input  logic           en,
  output logic [ddw-1:0] q,
  output logic           busy
`ifdef SEQ_DEADTIME_INTERLOCK_EN
  ,
  output logic           fault
`endif
);

  logic [ddw-1:0] r_d;
  logic           r_en;
  logic [ddw-1:0] w_req_raw;
  logic [ddw-1:0] w_req;
  logic [ddw-1:0] w_waiting;

  // An illegal pair count has no channel mapping; this block names it in the hierarchy.
  if (2 * pairs > ddw) begin : g_err_pairs_exceed_ddw
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d  <= '0;
      r_en <= 1'b0;
    end else begin
      r_d  <= d;
      r_en <= en;
    end
  end

  assign w_req_raw = r_d & {ddw{r_en}};

`ifdef SEQ_DEADTIME_INTERLOCK_EN
  logic [ddw-1:0] w_pair_mask;
  logic           r_fault;

  // Both halves of a pair requested together are both suppressed for that cycle.
  always_comb begin
    w_pair_mask = '0;
    for (int k = 0; k < pairs; k++) begin
      if (w_req_raw[2*k] && w_req_raw[2*k+1]) begin
        w_pair_mask[2*k]   = 1'b1;
        w_pair_mask[2*k+1] = 1'b1;
      end
    end
  end

  assign w_req = w_req_raw & ~w_pair_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fault <= 1'b0;
    else     r_fault <= r_fault | (|w_pair_mask);
  end

  assign fault = r_fault;
`else
  assign w_req = w_req_raw;
`endif

  for (genvar i = 0; i < ddw; i++) begin : g_chan
    seq_deadtime_chan #(
      .dt(dt)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .req     (w_req[i]),
      .q_bit   (q[i]),
      .waiting (w_waiting[i])
    );
  end

  assign busy = |w_waiting;

endmodule
